rhd_frame_packer: RTL and testbench

- Downstream stage of rhd_2048. Drains its sample FIFO (fifo_read_en / read data) and wraps each complete sample set in a host frame.
- Frame layout: magic header, frame counter, data words, XOR checksum trailer.
- Output is a 16-bit valid/ready stream with tlast, feeding the USB/DMA streamer.
- Detects and recovers from sample-set misalignment.

---
 rtl/rhd_pkg.sv | 40 ++++
 rtl/rhd_skid_fifo2.sv | 50 +++++
 rtl/rhd_frame_packer.sv | 204 ++++++++++++++++++++
 tb/tb_rhd_frame_packer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rhd_pkg.sv
// Shared definitions for the rhd_2048 host-frame packer and its helpers.
package rhd_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned HDR_WORDS = 4;
  localparam int unsigned CNT_WORDS = 2;
  localparam int unsigned TRL_WORDS = 1;

  localparam logic [DATA_W-1:0] MAGIC0 = 16'h1942;
  localparam logic [DATA_W-1:0] MAGIC1 = 16'h2702;
  localparam logic [DATA_W-1:0] MAGIC2 = 16'h1999;
  localparam logic [DATA_W-1:0] MAGIC3 = 16'hC691;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEEK = 3'd1,
    ST_HDR  = 3'd2,
    ST_CNT  = 3'd3,
    ST_DATA = 3'd4,
    ST_PAD  = 3'd5,
    ST_TRL  = 3'd6
  } state_t;

  // One sample word as delivered by the rhd_2048 FIFO.
  typedef struct packed {
    logic              sof;
    logic [DATA_W-1:0] data;
  } skid_word_t;

  // Header magic word by position within the header.
  function automatic logic [DATA_W-1:0] magic_word(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_word = MAGIC0;
      2'd1:    magic_word = MAGIC1;
      2'd2:    magic_word = MAGIC2;
      default: magic_word = MAGIC3;
    endcase
  endfunction

endpackage

// File: rtl/rhd_skid_fifo2.sv
// Two-entry buffer for sof-tagged sample words with occupancy output.
module rhd_skid_fifo2
  import rhd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  skid_word_t i_wdata,
  input  logic       i_pop,
  output skid_word_t o_head,
  output logic [1:0] o_count
);

  skid_word_t r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // Guard against pushing into a full or popping from an empty buffer.
  always_comb begin
    w_push = i_push && ((r_count != 2'd2) || i_pop);
    w_pop  = i_pop && (r_count != 2'd0);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/rhd_frame_packer.sv
// Wraps each rhd_2048 sample set in a host frame: magic, counter, data, XOR trailer.
module rhd_frame_packer
  import rhd_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = 2048,
  parameter logic [15:0] PAD_WORD        = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_sof,
  output logic        fifo_read_en,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [31:0] frame_count,
  output logic [15:0] sync_err_count,
  output logic        busy
);

  localparam logic [15:0] LAST_IDX = 16'(WORDS_PER_FRAME - 1);
  localparam logic [15:0] HDR_LAST = 16'(HDR_WORDS - 1);
  localparam logic [15:0] CNT_LAST = 16'(CNT_WORDS - 1);

  state_t      r_state;
  logic [15:0] r_idx;
  logic [15:0] r_csum;
  logic [15:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic [31:0] r_frame_count;
  logic [15:0] r_sync_err;
  logic        r_rd_inflight;

  skid_word_t  w_head;
  skid_word_t  w_wdata;
  logic [1:0]  w_count;
  logic        w_head_vld;
  logic        w_out_free;
  logic        w_pop;
  logic [2:0]  w_rd_room;
  logic        w_rd_state;

  assign w_wdata = '{sof: fifo_sof, data: fifo_dout};

  rhd_skid_fifo2 u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rd_inflight),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Skid pop decision and FIFO read request; room counts this cycle's pop.
  always_comb begin
    w_head_vld = (w_count != 2'd0);
    w_out_free = !r_tvalid || m_tready;
    w_pop      = 1'b0;
    case (r_state)
      ST_SEEK: w_pop = w_head_vld && !w_head.sof;
      ST_DATA: w_pop = w_head_vld && w_out_free && !((r_idx != 16'd0) && w_head.sof);
      default: w_pop = 1'b0;
    endcase
    w_rd_state   = (r_state == ST_SEEK) || (r_state == ST_DATA);
    w_rd_room    = 3'd2 - 3'(w_count) + 3'(w_pop);
    fifo_read_en = w_rd_state && !fifo_empty && (w_rd_room > 3'(r_rd_inflight));
  end

  // Frame sequencing, output register, checksum and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= 16'd0;
      r_csum        <= 16'd0;
      r_tdata       <= 16'd0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_frame_count <= 32'd0;
      r_sync_err    <= 16'd0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= fifo_read_en;

      if (r_tvalid && m_tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        if (r_tlast) begin
          r_frame_count <= r_frame_count + 32'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_SEEK;
          end
        end

        ST_SEEK: begin
          if (w_head_vld) begin
            if (w_head.sof) begin
              r_state <= ST_HDR;
              r_idx   <= 16'd0;
            end else if (r_sync_err != 16'hFFFF) begin
              r_sync_err <= r_sync_err + 16'd1;
            end
          end
        end

        ST_HDR: begin
          if (w_out_free) begin
            r_tdata  <= magic_word(r_idx[1:0]);
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            if (r_idx == HDR_LAST) begin
              r_state <= ST_CNT;
              r_idx   <= 16'd0;
            end else begin
              r_idx <= r_idx + 16'd1;
            end
          end
        end

        ST_CNT: begin
          if (w_out_free) begin
            r_tdata  <= (r_idx == 16'd0) ? r_frame_count[15:0] : r_frame_count[31:16];
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            if (r_idx == CNT_LAST) begin
              r_state <= ST_DATA;
              r_idx   <= 16'd0;
            end else begin
              r_idx <= r_idx + 16'd1;
            end
          end
        end

        ST_DATA: begin
          if (w_head_vld && w_out_free) begin
            if ((r_idx != 16'd0) && w_head.sof) begin
              // Early start of the next set: keep it, fill the rest of this frame.
              r_state <= ST_PAD;
              if (r_sync_err != 16'hFFFF) begin
                r_sync_err <= r_sync_err + 16'd1;
              end
            end else begin
              r_tdata  <= w_head.data;
              r_tvalid <= 1'b1;
              r_tlast  <= 1'b0;
              r_csum   <= r_csum ^ w_head.data;
              if (r_idx == LAST_IDX) begin
                r_state <= ST_TRL;
              end else begin
                r_idx <= r_idx + 16'd1;
              end
            end
          end
        end

        ST_PAD: begin
          if (w_out_free) begin
            r_tdata  <= PAD_WORD;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b0;
            r_csum   <= r_csum ^ PAD_WORD;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_TRL;
            end else begin
              r_idx <= r_idx + 16'd1;
            end
          end
        end

        ST_TRL: begin
          // Trailer is handed to the output register; the frame counter
          // advances when it is actually accepted downstream.
          if (w_out_free) begin
            r_tdata  <= r_csum;
            r_tvalid <= 1'b1;
            r_tlast  <= 1'b1;
            r_csum   <= 16'd0;
            r_idx    <= 16'd0;
            r_state  <= enable ? ST_SEEK : ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_tdata        = r_tdata;
  assign m_tvalid       = r_tvalid;
  assign m_tlast        = r_tlast;
  assign frame_count    = r_frame_count;
  assign sync_err_count = r_sync_err;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rhd_frame_packer.sv
// Directed bench for rhd_frame_packer with a 4-word frame.
module tb_rhd_frame_packer;

  localparam int unsigned WPF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_dout = 16'd0;
  logic        fifo_sof = 1'b0;
  logic        fifo_read_en;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic [31:0] frame_count;
  logic [15:0] sync_err_count;
  logic        busy;

  rhd_frame_packer #(.WORDS_PER_FRAME(WPF), .PAD_WORD(16'hFFFF)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_dout      (fifo_dout),
    .fifo_sof       (fifo_sof),
    .fifo_read_en   (fifo_read_en),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .frame_count    (frame_count),
    .sync_err_count (sync_err_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [16:0] src_q[$];
  logic [16:0] out_q[$];
  int          out_cyc[$];
  logic [16:0] exp_q[$];
  int          got_cyc[64];
  logic        pend = 1'b0;
  bit          rand_ready = 1'b0;
  bit          rand_empty = 1'b0;
  logic        stalled = 1'b0;
  logic [16:0] held = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Source FIFO model (1-cycle read latency) and output stream monitor.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (pend && src_q.size() > 0) begin
        {fifo_sof, fifo_dout} = src_q.pop_front();
      end
      pend       = 1'b0;
      fifo_empty = (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 0));
      m_tready   = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      #4;
      if (fifo_empty) check_eq("rd_while_empty", 32'(fifo_read_en), 32'd0);
      pend = fifo_read_en && !rst;
      if (stalled) check_eq("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, held}));
      stalled = m_tvalid && !m_tready;
      held    = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tlast, m_tdata});
        out_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic sof, input logic [15:0] d);
    src_q.push_back({sof, d});
  endtask

  task automatic push_set(input logic [15:0] a, b, c, d);
    push_word(1'b1, a); push_word(1'b0, b); push_word(1'b0, c); push_word(1'b0, d);
  endtask

  task automatic exp_frame(input logic [31:0] cnt, input logic [15:0] a, b, c, d, cs);
    exp_q.push_back({1'b0, 16'h1942}); exp_q.push_back({1'b0, 16'h2702});
    exp_q.push_back({1'b0, 16'h1999}); exp_q.push_back({1'b0, 16'hC691});
    exp_q.push_back({1'b0, cnt[15:0]}); exp_q.push_back({1'b0, cnt[31:16]});
    exp_q.push_back({1'b0, a}); exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c}); exp_q.push_back({1'b0, d});
    exp_q.push_back({1'b1, cs});
  endtask

  task automatic check_out(input string name);
    int          n;
    int          t;
    logic [16:0] obs;
    n = exp_q.size();
    t = 0;
    while (out_q.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (out_q.size() < n) check_eq({name, "_timeout"}, 32'(out_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (out_q.size() > 0) begin
        obs = out_q.pop_front();
        got_cyc[i] = out_cyc.pop_front();
      end else begin
        obs = 17'h1DEAD;
        got_cyc[i] = -1;
      end
      check_eq($sformatf("%s_w%0d", name, i), 32'(obs), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(m_tdata), 32'd0);
    check_eq("rst_tlast", 32'(m_tlast), 32'd0);
    check_eq("rst_fcnt", frame_count, 32'd0);
    check_eq("rst_serr", 32'(sync_err_count), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rden", 32'(fifo_read_en), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;

    // Single frame
    push_set(16'h1357, 16'h2468, 16'h0F0F, 16'h8001);
    exp_frame(32'd0, 16'h1357, 16'h2468, 16'h0F0F, 16'h8001, 16'hB831);
    check_out("f0");
    repeat (2) @(posedge clk);
    #1;
    check_eq("f0_fcnt", frame_count, 32'd1);
    check_eq("f0_serr", 32'(sync_err_count), 32'd0);

    // Back-to-back sets
    @(negedge clk);
    push_set(16'h1111, 16'h2222, 16'h4444, 16'h8888);
    push_set(16'h0001, 16'h0002, 16'h0004, 16'h0008);
    exp_frame(32'd1, 16'h1111, 16'h2222, 16'h4444, 16'h8888, 16'hFFFF);
    exp_frame(32'd2, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h000F);
    check_out("b2b");
    check_eq("b2b_gap", 32'(got_cyc[11] - got_cyc[10]), 32'd2);
    check_eq("b2b_span", 32'(got_cyc[21] - got_cyc[11]), 32'd10);
    repeat (2) @(posedge clk);
    #1;
    check_eq("b2b_fcnt", frame_count, 32'd3);

    // Leading garbage
    @(negedge clk);
    push_word(1'b0, 16'hDEAD); push_word(1'b0, 16'hBEEF); push_word(1'b0, 16'hCAFE);
    push_set(16'h00A5, 16'h5A00, 16'hFFFF, 16'h0000);
    exp_frame(32'd3, 16'h00A5, 16'h5A00, 16'hFFFF, 16'h0000, 16'hA55A);
    check_out("garb");
    #1;
    check_eq("garb_serr", 32'(sync_err_count), 32'd3);

    // Premature sof: truncated frame padded, early word starts the next frame
    @(negedge clk);
    push_word(1'b1, 16'h1234); push_word(1'b0, 16'h00FF);
    push_set(16'h5555, 16'h0A0A, 16'h3333, 16'h0101);
    exp_frame(32'd4, 16'h1234, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'h12CB);
    exp_frame(32'd5, 16'h5555, 16'h0A0A, 16'h3333, 16'h0101, 16'h6D6D);
    check_out("trunc");
    #1;
    check_eq("trunc_serr", 32'(sync_err_count), 32'd4);

    // Random backpressure and source gaps
    @(negedge clk);
    rand_ready = 1'b1;
    rand_empty = 1'b1;
    push_set(16'h1000, 16'h2000, 16'h3000, 16'h4000);
    push_set(16'h0F00, 16'h00F0, 16'h000F, 16'hF000);
    exp_frame(32'd6, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h4000);
    exp_frame(32'd7, 16'h0F00, 16'h00F0, 16'h000F, 16'hF000, 16'hFFFF);
    check_out("rnd");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rand_ready = 1'b0;
    rand_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rnd_fcnt", frame_count, 32'd8);
    check_eq("rnd_serr", 32'(sync_err_count), 32'd4);

    // Reset in the middle of DATA
    @(negedge clk);
    push_set(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    for (int t = 0; t < 500 && out_q.size() < 7; t++) @(negedge clk);
    check_eq("mid_reached", 32'(out_q.size() >= 7), 32'd1);
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mrst_tvalid", 32'(m_tvalid), 32'd0);
    check_eq("mrst_tdata", 32'(m_tdata), 32'd0);
    check_eq("mrst_tlast", 32'(m_tlast), 32'd0);
    check_eq("mrst_fcnt", frame_count, 32'd0);
    check_eq("mrst_serr", 32'(sync_err_count), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    src_q.delete();
    out_q.delete();
    out_cyc.delete();
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_idle", 32'(busy), 32'd0);
    check_eq("post_rst_out", 32'(out_q.size()), 32'd0);
    @(negedge clk);
    enable = 1'b1;
    push_set(16'h7E81, 16'h0001, 16'h0010, 16'h0100);
    exp_frame(32'd0, 16'h7E81, 16'h0001, 16'h0010, 16'h0100, 16'h7F90);
    check_out("rerun");
    repeat (2) @(posedge clk);
    #1;
    check_eq("rerun_fcnt", frame_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
